// File: rtl/kronos_fetch.sv
// RV32I instruction fetch stage: word fetches over req/ack, with one skid entry in front of the IF/ID pipe.
// Branch redirects flush both buffers. A fetch already in flight is drained and its data discarded.
package kronos_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;
endpackage

module kronos_fetch
    import kronos_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic [31:0] instr_data,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output pipeIFID_t   pipe_IFID,
    output logic        pipe_out_vld,
    input  logic        pipe_out_rdy
);

    logic [31:0] pc_q, pc_d;
    logic        rst_q, rst_d;
    pipeIFID_t   out_q, out_d;
    logic        out_vld_q, out_vld_d;
    pipeIFID_t   skid_q, skid_d;
    logic        skid_vld_q, skid_vld_d;
    logic        drop_q, drop_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        pend_q, pend_d;

    logic        ack_ok;
    logic        xfer;
    logic        out_free;
    pipeIFID_t   fetched;

    always_comb begin
        instr_req  = ~rst_q & ~skid_vld_q & ~branch;
        // While draining a flushed fetch, the old address stays on the bus.
        instr_addr = drop_q ? drop_addr_q : pc_q;
        ack_ok     = instr_ack & instr_req;
        xfer       = out_vld_q & pipe_out_rdy;
        out_free   = ~out_vld_q | xfer;
        fetched    = '{pc: pc_q, ir: instr_data};

        rst_d       = rst;
        pend_d      = instr_req & ~instr_ack;
        pc_d        = pc_q;
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_vld_d  = skid_vld_q;
        drop_d      = drop_q;
        drop_addr_d = drop_addr_q;

        if (branch) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            pc_d       = {branch_target[31:2], 2'b00};
            // An unacked request issued earlier must still complete on the bus.
            drop_d     = (drop_q | pend_q) & ~instr_ack;
            if (!drop_q) begin
                drop_addr_d = pc_q;
            end
        end else if (drop_q) begin
            if (ack_ok) begin
                drop_d = 1'b0;
            end
        end else begin
            if (xfer && skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = ack_ok;
                if (ack_ok) begin
                    skid_d = fetched;
                end
            end else if (ack_ok && out_free) begin
                out_d     = fetched;
                out_vld_d = 1'b1;
            end else if (ack_ok) begin
                skid_d     = fetched;
                skid_vld_d = 1'b1;
            end else if (xfer) begin
                out_vld_d = 1'b0;
            end

            if (ack_ok) begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= rst_d;
        if (rst) begin
            pc_q        <= BOOT_ADDR;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            drop_q      <= 1'b0;
            drop_addr_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            drop_q      <= drop_d;
            drop_addr_q <= drop_addr_d;
            pend_q      <= pend_d;
        end
    end

    assign pipe_IFID    = out_q;
    assign pipe_out_vld = out_vld_q;

endmodule

// File: doc/kronos_fetch.md
Name: kronos_fetch

Overview:
- RV32I instruction fetch stage; the producer end of the IF/ID pipe interface.
- Issues word fetches to instruction memory over a req/ack handshake and delivers {pc, ir} downstream on pipe_IFID with a vld/rdy handshake.
- Holds one skid entry so fetching can run at one instruction per cycle while the decode stage stalls.
- Accepts a branch redirect from later stages, which flushes all buffered instructions.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC of the first fetch after reset; must be word-aligned.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- instr_addr  out  32  fetch address, word-aligned.
- instr_req  out  1  fetch request; level signal held until the cycle it is acked.
- instr_ack  in  1  fetch complete; instr_data is valid in this cycle; may arrive in the same cycle as req.
- instr_data  in  32  fetched instruction word.
- branch  in  1  single-cycle redirect pulse.
- branch_target  in  32  new PC, sampled when branch=1; bits [1:0] are ignored and treated as 0.
- pipe_IFID  out  pipeIFID_t  {pc[31:0], ir[31:0]} of the instruction being offered downstream.
- pipe_out_vld  out  1  pipe_IFID is valid.
- pipe_out_rdy  in  1  downstream accepts; a transfer occurs when vld & rdy.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=BOOT_ADDR; pipe_out_vld=0; skid_vld=0; drop=0; pipe_IFID='0; instr_req=0 (registered low).
  - rst takes priority over every other input, including mid-fetch; an in-flight request is abandoned.
- instr_req = ~rst_q & ~skid_vld & ~branch, where rst_q is rst registered.
  - First req is issued the cycle after rst deasserts.
  - instr_addr = pc.
- Once asserted, addr and req stay stable until ack. The only exceptions are reset and the branch rule below.
- Ack with drop=0 and no branch in the same cycle:
  - If the output register is empty, or (vld & rdy), then {pc, instr_data} is loaded into the output register and vld=1 next cycle.
  - Otherwise it is loaded into the skid register (skid_vld=1).
  - pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC+4 = 0).
- Output transfer (vld & rdy) with skid_vld=1: the skid entry moves to the output register and skid_vld=0. A same-cycle ack then lands in the skid (order is preserved).
- Output transfer with skid empty and no ack: vld=0.
- Latency:
  - With ack in the same cycle as req, the instruction is on pipe_IFID the next cycle.
  - Sustained throughput is 1 instr/cycle when rdy=1 and ack is single-cycle.
- Stall: the skid is full only while the output is held; req stays low until the output transfers.
- Branch (branch=1):
  - Next cycle: pipe_out_vld=0, skid_vld=0, pc=branch_target.
  - instr_req is forced low in the branch cycle.
  - If a fetch was outstanding (req was high and no ack in the branch cycle), set drop=1.
  - While drop=1: req stays high at the old addr until ack. That ack's data is discarded and drop clears; the target fetch begins the following cycle with instr_addr=target.
  - A branch in the same cycle as an ack discards the acked data; drop is not set.
  - A branch in the same cycle as an output transfer: the transfer counts as done, and the flush still applies.
  - A second branch while drop=1 updates pc to the new target; drop stays 1.
- pipe_IFID must hold stable while vld=1 and rdy=0.
- Ordering: instructions leave in fetch order. None is duplicated; none is lost except by flush.

Test Plan:
- Reset release with BOOT_ADDR=0x100, same-cycle ack, rdy=1:
  - req in cycle 1 with addr 0x100.
  - vld in cycle 2 with pc=0x100 and ir=data.
  - Addresses 0x104, 0x108 follow back-to-back, one per cycle.
- Stall with rdy=0 for 5 cycles:
  - Output holds pc=0x100; skid captures 0x104; req drops.
  - On rdy=1, 0x100 then 0x104 transfer on consecutive cycles and fetch resumes at 0x108.
- Memory ack delayed 3 cycles:
  - instr_addr and req stay stable through the wait.
  - vld rises exactly one cycle after ack.
- Branch to 0x2000 with vld=1 and skid full: next cycle vld=0 and the first new fetch addr is 0x2000.
- Branch to 0x3000 while a fetch to 0x10C is outstanding (ack 2 cycles later):
  - 0x10C data is never presented downstream.
  - The next req is addr 0x3000.
  - The next pipe_IFID.pc is 0x3000.
- PC wrap and mid-operation reset:
  - Fetch at 0xFFFF_FFFC is followed by addr 0x0.
  - rst asserted with vld=1 and skid full clears all valids, and the next req after release is BOOT_ADDR.
